// File: rtl/basys3_ui_pkg.sv
// Shared timing defaults and the auto-repeat state type for the Basys 3 button front end.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package basys3_ui_pkg;

    // Defaults assume a 100 MHz clk.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;   // 10 ms
    localparam int DEFAULT_REPEAT_DELAY    = 50_000_000;  // 500 ms
    localparam int DEFAULT_REPEAT_PERIOD   = 10_000_000;  // 100 ms

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

endpackage

// File: rtl/btn_debounce_channel.sv
// One button: 2-flop synchronizer, stable-count debounce, press/release pulses and auto-repeat.
// Latency: raw edge reaches level/press/release 2 + DEBOUNCE_CYCLES cycles later; all outputs registered.
// Backpressure: none; pulses are single-cycle and are not held for a consumer.
module btn_debounce_channel
    import basys3_ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RP_W   = $clog2(RP_MAX) + 1;

    // Counter values on which the next increment would hit the target count.
    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] DELAY_LAST  = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);

    logic            sync_meta;
    logic            sync;
    logic [DB_W-1:0] db_cnt;
    logic            accept;
    logic            level_rise;
    logic            level_fall;

    rpt_state_t      state_q;
    rpt_state_t      state_d;
    logic [RP_W-1:0] rcnt_q;
    logic [RP_W-1:0] rcnt_d;
    logic            press_d;

    // The level flips on the edge where the stable-count would reach its target.
    assign accept     = (sync != level) && (db_cnt == DB_LAST);
    assign level_rise = accept && !level;
    assign level_fall = accept && level;

    // Two-flop synchronizer; only the second stage is used downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync      <= sync_meta;
        end
    end

    // Debounce: count consecutive cycles of disagreement, any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt <= '0;
            level  <= 1'b0;
        end else if (sync == level) begin
            db_cnt <= '0;
        end else if (accept) begin
            db_cnt <= '0;
            level  <= ~level;
        end else if (db_cnt != '1) begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Repeat FSM state, repeat counter and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RPT_IDLE;
            rcnt_q        <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state_q       <= state_d;
            rcnt_q        <= rcnt_d;
            press_pulse   <= press_d;
            release_pulse <= level_fall;
        end
    end

    // Next-state: release wins over any pending repeat so press and release never coincide.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        press_d = 1'b0;
        if (level_fall) begin
            state_d = RPT_IDLE;
            rcnt_d  = '0;
        end else begin
            case (state_q)
                RPT_IDLE: begin
                    if (level_rise) begin
                        state_d = RPT_DELAY;
                        rcnt_d  = '0;
                        press_d = 1'b1;
                    end
                end
                RPT_DELAY: begin
                    if (rcnt_q == DELAY_LAST) begin
                        state_d = RPT_REPEAT;
                        rcnt_d  = '0;
                        press_d = 1'b1;
                    end else if (rcnt_q != '1) begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                RPT_REPEAT: begin
                    if (rcnt_q == PERIOD_LAST) begin
                        rcnt_d  = '0;
                        press_d = 1'b1;
                    end else if (rcnt_q != '1) begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = RPT_IDLE;
                    rcnt_d  = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Conditions BUTTON_COUNT raw buttons into debounced levels, press (with auto-repeat) and release pulses.
// Latency: 2 + DEBOUNCE_CYCLES cycles from raw edge to outputs; every output is a flop.
// Backpressure: none; channels run independently with no arbitration between them.
module btn_conditioner
    import basys3_ui_pkg::*;
#(
    parameter int BUTTON_COUNT    = 5,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BUTTON_COUNT-1:0] btn_raw,
    output logic [BUTTON_COUNT-1:0] btn_level,
    output logic [BUTTON_COUNT-1:0] btn_press,
    output logic [BUTTON_COUNT-1:0] btn_release
);

    for (genvar i = 0; i < BUTTON_COUNT; i++) begin : g_chan
        btn_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .raw           (btn_raw[i]),
            .level         (btn_level[i]),
            .press_pulse   (btn_press[i]),
            .release_pulse (btn_release[i])
        );
    end

endmodule
